seg7_capture: RTL and testbench
===============================

# seg7_capture

Decoder for the active-low seven-segment patterns that our hex display encoder drives onto HEX5/HEX4. It converts a pair of segment patterns back into the 8-bit value they represent. It accepts a pair through a valid/ready handshake and filters glitches by requiring the pattern to hold stable for a programmable number of cycles. It then presents the decoded byte and per-digit error flags on a registered output with valid/ready. It sits on the display side of the ALU datapath and gives the bench and on-board loopback a way to read the register value back from the segment outputs.

## Interface
- STABLE_CYCLES, 4: number of consecutive matching cycles required after accept before decode; legal range 1..255.
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- seg_hi  in  7  segment pattern for the upper nibble, active-low; bit0 = segment a … bit6 = segment g.
- seg_lo  in  7  segment pattern for the lower nibble, same encoding.
- in_valid  in  1  the source presents a pattern pair.
- in_ready  out  1  the block can accept; high only in IDLE.
- out_valid  out  1  decoded result available.
- out_ready  in  1  the sink takes the result.
- out_data  out  8  {nibble(seg_hi), nibble(seg_lo)}.
- err  out  2  bit1: seg_hi is not a legal digit; bit0: seg_lo is not a legal digit.
- glitch_count  out  8  saturating count of filter restarts since reset.

## Operation
- **Legal patterns (hex, active-low), 0..F:** 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, 08, 03, 46, 21, 06, 0E.
  - Any other pattern, including blank 7F, is illegal.
  - An illegal pattern decodes to nibble 0 and sets the corresponding err bit.
- **IDLE:**
  - in_ready = 1.
  - On in_valid & in_ready: cap_hi/cap_lo <= seg_hi/seg_lo, cnt <= 0, go to FILTER.
- **FILTER:**
  - in_ready = 0. Each edge compares the live {seg_hi, seg_lo} against the captured pair.
  - On a match: cnt <= cnt + 1. If cnt + 1 == STABLE_CYCLES, go to DONE and register out_data, err, and out_valid = 1.
  - On a mismatch: re-capture the live pair, set cnt <= 0, increment glitch_count (saturates at FF), stay in FILTER.
  - in_valid is ignored in FILTER; the source must keep its pattern driven.
- **DONE:**
  - out_valid = 1. out_data and err stay constant until the handshake completes.
  - On out_valid & out_ready: go to IDLE, out_valid <= 0. out_data and err keep their last value.
  - in_valid is ignored in DONE.
- **Widths:** cnt is 8 bits; the compare is against STABLE_CYCLES exactly, with no wrap. glitch_count never wraps.
- **Reset (asynchronous, any state, including mid-FILTER or DONE):**
  - State -> IDLE.
  - out_valid = 0, out_data = 00, err = 00, glitch_count = 00, cnt = 0, captured pair = 7F/7F.
  - in_ready = 1 during and after reset, since it is decoded from the IDLE state.

## Timing
- in_ready is combinational from state only; it has no combinational path from in_valid.
- out_valid, out_data, and err are registered; there is no combinational path from the inputs.
- **Latency with no glitch:** accept at edge E0; out_valid rises after edge E(STABLE_CYCLES).
- **Latency with glitches:** each mismatch restarts the count, so latency becomes STABLE_CYCLES edges after the last mismatch edge.
- **Throughput:** at most one pair every STABLE_CYCLES + 2 cycles. The DONE->IDLE edge and the next accept edge are distinct.
- **Sink behaviour:** out_ready held high consumes the result on the first edge out_valid is high. out_ready low holds DONE indefinitely.
- **Boundary, STABLE_CYCLES = 1:** the first matching edge after accept moves to DONE.
- **Boundary, mismatch at the final compare edge:** this restarts the count; DONE is not entered.

## Test plan
- Reset, then seg_hi = 30, seg_lo = 19, in_valid pulse with input held stable, STABLE_CYCLES = 4 -> out_valid rises 4 edges after accept, out_data = 34, err = 00, glitch_count = 00.
- seg_hi = 06 (E), seg_lo = 7F (blank) -> out_data = E0, err = 01. Also seg_hi = 7E, seg_lo = 40 -> out_data = 00, err = 10.
- Accept 12/02, change seg_lo to 78 at the 2nd compare edge and then hold -> glitch_count = 01, out_data = 57, out_valid 4 edges after the change.
- out_ready held low for 10 cycles in DONE with in_valid = 1 and the inputs changing -> out_valid, out_data, and in_ready = 0 unchanged. Raising out_ready -> out_valid low next edge, in_ready high.
- Assert reset_n low mid-FILTER, asynchronously between edges -> out_valid = 0, in_ready = 1, glitch_count = 00 immediately, without waiting for a clock edge.
- Force 300 mismatches -> glitch_count saturates at FF. Sweep all 16 legal codes -> each decodes correctly with err = 00.

Source files
------------

// File: rtl/seg7_capture_if.sv
// Handshake bundle between a segment-pattern source/sink and seg7_capture.
// The master side drives patterns and takes results; the slave side is the decoder.
interface seg7_capture_if;
   logic [6:0] seg_hi;
   logic [6:0] seg_lo;
   logic       in_valid;
   logic       in_ready;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [1:0] err;

   modport master (
      output seg_hi, seg_lo, in_valid, out_ready,
      input  in_ready, out_valid, out_data, err
   );

   modport slave (
      input  seg_hi, seg_lo, in_valid, out_ready,
      output in_ready, out_valid, out_data, err
   );
endinterface

// File: rtl/seg7_capture.sv
// Decodes a pair of active-low seven-segment patterns back into a byte, accepting
// a pattern only after it has held stable for STABLE_CYCLES consecutive edges.
module seg7_capture #(
   parameter int unsigned STABLE_CYCLES = 4  // legal range 1..255
) (
   input  logic            clock,
   input  logic            reset_n,
   seg7_capture_if.slave   bus,
   output logic [7:0]      glitch_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILTER,
      S_DONE
   } state_e;

   // The final compare happens when cnt already holds STABLE_CYCLES-1, so the
   // match test needs no wider adder and cannot wrap.
   localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);
   localparam logic [6:0] BLANK    = 7'h7F;

   // Returns {illegal, nibble}; illegal patterns decode to nibble 0.
   function automatic logic [4:0] decode(input logic [6:0] seg);
      logic [4:0] r;
      case (seg)
         7'h40:   r = 5'h00;
         7'h79:   r = 5'h01;
         7'h24:   r = 5'h02;
         7'h30:   r = 5'h03;
         7'h19:   r = 5'h04;
         7'h12:   r = 5'h05;
         7'h02:   r = 5'h06;
         7'h78:   r = 5'h07;
         7'h00:   r = 5'h08;
         7'h10:   r = 5'h09;
         7'h08:   r = 5'h0A;
         7'h03:   r = 5'h0B;
         7'h46:   r = 5'h0C;
         7'h21:   r = 5'h0D;
         7'h06:   r = 5'h0E;
         7'h0E:   r = 5'h0F;
         default: r = 5'h10;
      endcase
      return r;
   endfunction

   state_e     state_q,     state_d;
   logic [6:0] cap_hi_q,    cap_hi_d;
   logic [6:0] cap_lo_q,    cap_lo_d;
   logic [7:0] cnt_q,       cnt_d;
   logic [7:0] out_data_q,  out_data_d;
   logic [1:0] err_q,       err_d;
   logic       out_valid_q, out_valid_d;
   logic [7:0] glitch_q,    glitch_d;

   logic [4:0] dec_hi;
   logic [4:0] dec_lo;
   logic       pair_match;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path leaves
      // it unassigned and no latch is inferred.
      state_d     = state_q;
      cap_hi_d    = cap_hi_q;
      cap_lo_d    = cap_lo_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      err_d       = err_q;
      out_valid_d = out_valid_q;
      glitch_d    = glitch_q;

      dec_hi     = decode(cap_hi_q);
      dec_lo     = decode(cap_lo_q);
      pair_match = ({bus.seg_hi, bus.seg_lo} == {cap_hi_q, cap_lo_q});

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               cap_hi_d = bus.seg_hi;
               cap_lo_d = bus.seg_lo;
               cnt_d    = 8'd0;
               state_d  = S_FILTER;
            end
         end

         S_FILTER: begin
            if (pair_match) begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == LAST_CNT) begin
                  state_d     = S_DONE;
                  out_valid_d = 1'b1;
                  out_data_d  = {dec_hi[3:0], dec_lo[3:0]};
                  err_d       = {dec_hi[4], dec_lo[4]};
               end
            end else begin
               // A change restarts the stability window on the new pattern.
               cap_hi_d = bus.seg_hi;
               cap_lo_d = bus.seg_lo;
               cnt_d    = 8'd0;
               if (glitch_q != 8'hFF) begin
                  glitch_d = glitch_q + 8'd1;
               end
            end
         end

         S_DONE: begin
            if (bus.out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         cap_hi_q    <= BLANK;
         cap_lo_q    <= BLANK;
         cnt_q       <= 8'd0;
         out_data_q  <= 8'h00;
         err_q       <= 2'b00;
         out_valid_q <= 1'b0;
         glitch_q    <= 8'h00;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values from
         // before this edge, independent of statement order.
         state_q     <= state_d;
         cap_hi_q    <= cap_hi_d;
         cap_lo_q    <= cap_lo_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
         glitch_q    <= glitch_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.err       = err_q;
   assign glitch_count  = glitch_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: latency, decode, glitch restart, sink stall,
// async reset, glitch saturation, full legal-code sweep and the 1-cycle filter.
module tb_seg7_capture;

   logic       clock   = 1'b0;
   logic       reset_n = 1'b1;
   logic [7:0] gc0;
   logic [7:0] gc1;
   int         total = 0;
   int         bad   = 0;
   int         lat;

   logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seg7_capture_if bus0 ();
   seg7_capture_if bus1 ();

   seg7_capture #(.STABLE_CYCLES(4)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .bus          (bus0),
      .glitch_count (gc0)
   );

   seg7_capture #(.STABLE_CYCLES(1)) dut1 (
      .clock        (clock),
      .reset_n      (reset_n),
      .bus          (bus1),
      .glitch_count (gc1)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [6:0] hi, input logic [6:0] lo);
      bus0.seg_hi   = hi;
      bus0.seg_lo   = lo;
      bus0.in_valid = 1'b1;
      tick();
      bus0.in_valid = 1'b0;
   endtask

   // Edges counted after the accept edge until out_valid, bounded.
   task automatic wait_valid(output int n);
      n = 0;
      while (bus0.out_valid !== 1'b1 && n < 64) begin
         tick();
         n++;
      end
   endtask

   task automatic consume;
      bus0.out_ready = 1'b1;
      tick();
      bus0.out_ready = 1'b0;
   endtask

   initial begin
      bus0.seg_hi = 7'h7F; bus0.seg_lo = 7'h7F; bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
      bus1.seg_hi = 7'h7F; bus1.seg_lo = 7'h7F; bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;

      // Reset values, observed before any clock edge.
      #1 reset_n = 1'b0;
      #1;
      check("rst_in_ready",  32'(bus0.in_ready),  32'h1);
      check("rst_out_valid", 32'(bus0.out_valid), 32'h0);
      check("rst_out_data",  32'(bus0.out_data),  32'h00);
      check("rst_err",       32'(bus0.err),       32'h0);
      check("rst_glitch",    32'(gc0),            32'h00);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      tick();

      // Basic decode 30/19 -> 34, four edges after accept.
      send(7'h30, 7'h19);
      check("t1_in_ready_low", 32'(bus0.in_ready), 32'h0);
      wait_valid(lat);
      check("t1_latency",  32'(lat),            32'd4);
      check("t1_data",     32'(bus0.out_data),  32'h34);
      check("t1_err",      32'(bus0.err),       32'h0);
      check("t1_glitch",   32'(gc0),            32'h00);
      check("t1_ready_done", 32'(bus0.in_ready), 32'h0);
      consume();
      check("t1_valid_drop", 32'(bus0.out_valid), 32'h0);
      check("t1_ready_back", 32'(bus0.in_ready),  32'h1);
      check("t1_data_kept",  32'(bus0.out_data),  32'h34);

      // Illegal patterns flag err and decode to 0.
      send(7'h06, 7'h7F);
      wait_valid(lat);
      check("t2a_latency", 32'(lat),           32'd4);
      check("t2a_data",    32'(bus0.out_data), 32'hE0);
      check("t2a_err",     32'(bus0.err),      32'h1);
      consume();
      send(7'h7E, 7'h40);
      wait_valid(lat);
      check("t2b_data",    32'(bus0.out_data), 32'h00);
      check("t2b_err",     32'(bus0.err),      32'h2);
      consume();

      // Glitch on the 2nd compare edge restarts the window.
      send(7'h12, 7'h02);
      tick();
      bus0.seg_lo = 7'h78;
      tick();
      check("t3_no_valid", 32'(bus0.out_valid), 32'h0);
      check("t3_glitch",   32'(gc0),            32'h01);
      wait_valid(lat);
      check("t3_latency",  32'(lat),            32'd4);
      check("t3_data",     32'(bus0.out_data),  32'h57);
      check("t3_err",      32'(bus0.err),       32'h0);

      // Sink stalls in DONE while the source keeps changing and asserting valid.
      bus0.in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus0.seg_hi = 7'(i * 13);
         bus0.seg_lo = 7'(i * 7 + 1);
         tick();
         check("t4_hold_valid", 32'(bus0.out_valid), 32'h1);
         check("t4_hold_data",  32'(bus0.out_data),  32'h57);
         check("t4_hold_ready", 32'(bus0.in_ready),  32'h0);
      end
      bus0.in_valid = 1'b0;
      consume();
      check("t4_valid_drop", 32'(bus0.out_valid), 32'h0);
      check("t4_ready_back", 32'(bus0.in_ready),  32'h1);
      check("t4_glitch",     32'(gc0),            32'h01);

      // Mismatch exactly at the final compare edge: no DONE.
      send(7'h24, 7'h79);
      repeat (3) tick();
      bus0.seg_hi = 7'h30;
      tick();
      check("t5_no_done", 32'(bus0.out_valid), 32'h0);
      check("t5_glitch",  32'(gc0),            32'h02);
      wait_valid(lat);
      check("t5_latency", 32'(lat),            32'd4);
      check("t5_data",    32'(bus0.out_data),  32'h31);
      consume();

      // Asynchronous reset mid-FILTER, between edges.
      send(7'h40, 7'h40);
      tick();
      #3 reset_n = 1'b0;
      #1;
      check("t6a_valid",  32'(bus0.out_valid), 32'h0);
      check("t6a_ready",  32'(bus0.in_ready),  32'h1);
      check("t6a_glitch", 32'(gc0),            32'h00);
      check("t6a_data",   32'(bus0.out_data),  32'h00);
      #2 reset_n = 1'b1;
      tick();

      // Asynchronous reset while holding a result in DONE.
      send(7'h08, 7'h03);
      wait_valid(lat);
      check("t6b_data_pre", 32'(bus0.out_data), 32'hAB);
      #3 reset_n = 1'b0;
      #1;
      check("t6b_valid", 32'(bus0.out_valid), 32'h0);
      check("t6b_ready", 32'(bus0.in_ready),  32'h1);
      check("t6b_data",  32'(bus0.out_data),  32'h00);
      #2 reset_n = 1'b1;
      tick();

      // 300 consecutive mismatches saturate glitch_count.
      send(7'h00, 7'h00);
      for (int i = 0; i < 300; i++) begin
         bus0.seg_lo = i[0] ? 7'h00 : 7'h10;
         tick();
         if (i == 253) check("t7_glitch_fe", 32'(gc0), 32'hFE);
      end
      check("t7_glitch_ff", 32'(gc0),            32'hFF);
      check("t7_no_valid",  32'(bus0.out_valid), 32'h0);
      wait_valid(lat);
      check("t7_latency",   32'(lat),            32'd4);
      check("t7_data",      32'(bus0.out_data),  32'h88);
      consume();

      // Every legal code, in both digit positions.
      for (int i = 0; i < 16; i++) begin
         send(codes[i], codes[15 - i]);
         wait_valid(lat);
         check("t8_data", 32'(bus0.out_data), 32'((i << 4) | (15 - i)));
         check("t8_err",  32'(bus0.err),      32'h0);
         consume();
      end
      check("t8_glitch", 32'(gc0), 32'hFF);

      // STABLE_CYCLES = 1: first matching edge after accept reaches DONE.
      bus1.seg_hi   = 7'h79;
      bus1.seg_lo   = 7'h46;
      bus1.in_valid = 1'b1;
      tick();
      bus1.in_valid = 1'b0;
      check("t9_accept_no_valid", 32'(bus1.out_valid), 32'h0);
      tick();
      check("t9_valid", 32'(bus1.out_valid), 32'h1);
      check("t9_data",  32'(bus1.out_data),  32'h1C);
      check("t9_err",   32'(bus1.err),       32'h0);
      bus1.out_ready = 1'b1;
      tick();
      bus1.out_ready = 1'b0;
      check("t9_valid_drop", 32'(bus1.out_valid), 32'h0);
      check("t9_ready_back", 32'(bus1.in_ready),  32'h1);
      check("t9_glitch",     32'(gc1),            32'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
